// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter. Sends one command byte to the
// keyboard: inhibit, request-to-send, 8 data bits LSB first, odd parity, stop,
// then checks the device ACK. Lines are driven open-drain through output enables.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       send,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_ONE  = INH_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_RTS,
    S_DATA,
    S_PARITY,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  logic [1:0]       rst_sync;
  logic             rst_int_n;
  logic [1:0]       clk_sync;
  logic [1:0]       dat_sync;
  logic             clk_prev;
  logic             ps2_fall;
  logic             in_xfer;

  state_t           state, state_n;
  logic [7:0]       data_q, data_n;
  logic             parity_q, parity_n;
  logic             dat_oe_q, dat_oe_n;
  logic [3:0]       bit_cnt, bit_cnt_n;
  logic [INH_W-1:0] inh_cnt, inh_cnt_n;
  logic [TO_W-1:0]  to_cnt, to_cnt_n;
  logic             done_q, done_n;
  logic             err_q, err_n;

  assign rst_int_n = rst_sync[1];

  // Reset asserts immediately but is released only after two clock edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  // Bring both raw bus lines into the clk domain; idle bus reads high
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_in};
      dat_sync <= {dat_sync[0], ps2_dat_in};
      clk_prev <= clk_sync[1];
    end
  end

  assign ps2_fall = clk_prev & ~clk_sync[1];
  assign in_xfer  = (state == S_RTS) || (state == S_DATA) || (state == S_PARITY) ||
                    (state == S_ACK) || (state == S_WAIT_IDLE);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state    <= S_IDLE;
      data_q   <= 8'h00;
      parity_q <= 1'b0;
      dat_oe_q <= 1'b0;
      bit_cnt  <= 4'd0;
      inh_cnt  <= '0;
      to_cnt   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      data_q   <= data_n;
      parity_q <= parity_n;
      dat_oe_q <= dat_oe_n;
      bit_cnt  <= bit_cnt_n;
      inh_cnt  <= inh_cnt_n;
      to_cnt   <= to_cnt_n;
      done_q   <= done_n;
      err_q    <= err_n;
    end
  end

  // Sequence the frame on synchronised falling edges; timeout overrides everything
  always_comb begin
    state_n   = state;
    data_n    = data_q;
    parity_n  = parity_q;
    dat_oe_n  = dat_oe_q;
    bit_cnt_n = bit_cnt;
    inh_cnt_n = inh_cnt;
    to_cnt_n  = to_cnt;
    done_n    = 1'b0;
    err_n     = 1'b0;

    if (in_xfer) to_cnt_n = to_cnt + TO_ONE;

    case (state)
      S_IDLE: begin
        dat_oe_n = 1'b0;
        if (send) begin
          data_n   = data;
          parity_n = ~^data;
          state_n  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (inh_cnt == INH_LAST) begin
          dat_oe_n = 1'b1;
          state_n  = S_START;
        end else begin
          inh_cnt_n = inh_cnt + INH_ONE;
        end
      end
      S_START: begin
        state_n = S_RTS;
      end
      S_RTS: begin
        if (ps2_fall) begin
          dat_oe_n  = ~data_q[0];
          bit_cnt_n = 4'd1;
          state_n   = S_DATA;
        end
      end
      S_DATA: begin
        if (ps2_fall) begin
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd8) begin
            dat_oe_n = ~parity_q;
            state_n  = S_PARITY;
          end else begin
            dat_oe_n = ~data_q[bit_cnt[2:0]];
          end
        end
      end
      S_PARITY: begin
        if (ps2_fall) begin
          bit_cnt_n = 4'd10;
          dat_oe_n  = 1'b0;
          state_n   = S_ACK;
        end
      end
      S_ACK: begin
        if (ps2_fall) begin
          bit_cnt_n = 4'd11;
          if (!dat_sync[1]) begin
            state_n = S_WAIT_IDLE;
          end else begin
            err_n   = 1'b1;
            state_n = S_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (clk_sync[1] && dat_sync[1]) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (in_xfer && (to_cnt == TO_LAST)) begin
      done_n   = 1'b0;
      err_n    = 1'b1;
      dat_oe_n = 1'b0;
      state_n  = S_IDLE;
    end

    if (state_n == S_IDLE) begin
      dat_oe_n  = 1'b0;
      bit_cnt_n = 4'd0;
      inh_cnt_n = '0;
      to_cnt_n  = '0;
    end
  end

  assign ps2_clk_oe = (state == S_INHIBIT) || (state == S_START);
  assign ps2_dat_oe = dat_oe_q;
  assign busy       = (state != S_IDLE);
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a simple PS/2 device
// model sharing wired-AND bus lines with the host.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TMO = 2000;
  localparam int H   = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] data = 8'h00;
  logic       send = 1'b0;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_oe, ps2_dat_oe, busy, done, err;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int long_cnt = 0;
  logic prev_done = 1'b0;
  logic prev_err = 1'b0;
  logic [10:0] dev_smp;

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .send(send),
    .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Pulse monitor sampled away from the active edge
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (done && err) both_cnt++;
    if ((done && prev_done) || (err && prev_err)) long_cnt++;
    prev_done <= done;
    prev_err  <= err;
  end

  task automatic do_send(input logic [7:0] d);
    @(negedge clk);
    data = d;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
  endtask

  task automatic run_device(input bit ack, input int first, input int last);
    for (int k = first; k < last; k++) begin
      repeat (H) @(negedge clk);
      dev_smp[k] = ps2_dat_in;
      if (k == 10 && ack) begin
        dev_dat_low = 1'b1;
        repeat (3) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b0;
    end
    if (last == 11) begin
      repeat (H) @(negedge clk);
      dev_dat_low = 1'b0;
    end
  endtask

  task automatic wait_rts(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < INH + 20; i++) begin
      if (busy && !ps2_clk_oe && ps2_dat_oe) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    data = 8'hFF;
    send = 1'b1;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (ps2_clk_oe !== 1'b0) begin bad++; $display("[TB] FAIL reset_clk_oe: got %b expected 0", ps2_clk_oe); end
    total++; if (ps2_dat_oe !== 1'b0) begin bad++; $display("[TB] FAIL reset_dat_oe: got %b expected 0", ps2_dat_oe); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    total++; if (done !== 1'b0 || err !== 1'b0) begin bad++; $display("[TB] FAIL reset_pulses: got done=%b err=%b expected 0 0", done, err); end
    send = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_release_busy: got %b expected 0", busy); end
  endtask

  task automatic test_tx(input string name, input logic [7:0] d, input logic [10:0] exp);
    int d0, e0, n;
    bit ok;
    d0 = done_cnt;
    e0 = err_cnt;
    do_send(d);
    total++; if (busy !== 1'b1 || ps2_clk_oe !== 1'b1 || ps2_dat_oe !== 1'b0) begin bad++; $display("[TB] FAIL %s_accept: got busy=%b clk_oe=%b dat_oe=%b expected 1 1 0", name, busy, ps2_clk_oe, ps2_dat_oe); end
    n = 0;
    while (ps2_clk_oe && !ps2_dat_oe && n < INH + 10) begin
      n++;
      @(negedge clk);
    end
    total++; if (n != INH) begin bad++; $display("[TB] FAIL %s_inhibit_len: got %0d expected %0d", name, n, INH); end
    total++; if (ps2_clk_oe !== 1'b1 || ps2_dat_oe !== 1'b1) begin bad++; $display("[TB] FAIL %s_start: got clk_oe=%b dat_oe=%b expected 1 1", name, ps2_clk_oe, ps2_dat_oe); end
    @(negedge clk);
    total++; if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b1) begin bad++; $display("[TB] FAIL %s_rts: got clk_oe=%b dat_oe=%b expected 0 1", name, ps2_clk_oe, ps2_dat_oe); end
    dev_smp = '0;
    run_device(1'b1, 0, 11);
    total++; if (dev_smp !== exp) begin bad++; $display("[TB] FAIL %s_bits: got %b expected %b", name, dev_smp, exp); end
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL %s_idle: got busy=%b expected 0", name, busy); end
    repeat (3) @(negedge clk);
    total++; if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin bad++; $display("[TB] FAIL %s_result: got done=%0d err=%0d expected 1 0", name, done_cnt - d0, err_cnt - e0); end
    total++; if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin bad++; $display("[TB] FAIL %s_released: got clk_oe=%b dat_oe=%b expected 0 0", name, ps2_clk_oe, ps2_dat_oe); end
  endtask

  task automatic test_no_ack();
    int d0, e0;
    bit ok;
    d0 = done_cnt;
    e0 = err_cnt;
    do_send(8'h01);
    wait_rts(ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL noack_rts: got timeout expected rts"); end
    dev_smp = '0;
    run_device(1'b0, 0, 11);
    wait_idle(ok);
    repeat (3) @(negedge clk);
    total++; if (dev_smp !== 11'b10000000010) begin bad++; $display("[TB] FAIL noack_bits: got %b expected %b", dev_smp, 11'b10000000010); end
    total++; if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin bad++; $display("[TB] FAIL noack_result: got err=%0d done=%0d expected 1 0", err_cnt - e0, done_cnt - d0); end
    total++; if (busy !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin bad++; $display("[TB] FAIL noack_released: got busy=%b clk_oe=%b dat_oe=%b expected 0 0 0", busy, ps2_clk_oe, ps2_dat_oe); end
  endtask

  task automatic test_timeout();
    int d0, e0, n;
    bit ok;
    d0 = done_cnt;
    e0 = err_cnt;
    do_send(8'hA5);
    wait_rts(ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL timeout_rts: got timeout expected rts"); end
    n = 0;
    while (!err && n < TMO + 50) begin
      @(negedge clk);
      n++;
    end
    total++; if (n != TMO) begin bad++; $display("[TB] FAIL timeout_len: got %0d expected %0d", n, TMO); end
    total++; if (busy !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin bad++; $display("[TB] FAIL timeout_released: got busy=%b clk_oe=%b dat_oe=%b expected 0 0 0", busy, ps2_clk_oe, ps2_dat_oe); end
    repeat (3) @(negedge clk);
    total++; if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin bad++; $display("[TB] FAIL timeout_result: got err=%0d done=%0d expected 1 0", err_cnt - e0, done_cnt - d0); end
  endtask

  task automatic test_busy_ignore();
    int d0, e0;
    bit ok;
    d0 = done_cnt;
    e0 = err_cnt;
    do_send(8'hED);
    wait_rts(ok);
    do_send(8'h55);
    total++; if (busy !== 1'b1 || ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b1) begin bad++; $display("[TB] FAIL ignore_rts_kept: got busy=%b clk_oe=%b dat_oe=%b expected 1 0 1", busy, ps2_clk_oe, ps2_dat_oe); end
    dev_smp = '0;
    run_device(1'b1, 0, 4);
    do_send(8'h55);
    run_device(1'b1, 4, 11);
    total++; if (dev_smp !== 11'b11111011010) begin bad++; $display("[TB] FAIL ignore_bits: got %b expected %b", dev_smp, 11'b11111011010); end
    wait_idle(ok);
    repeat (3) @(negedge clk);
    total++; if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin bad++; $display("[TB] FAIL ignore_result: got done=%0d err=%0d expected 1 0", done_cnt - d0, err_cnt - e0); end
  endtask

  task automatic test_reset_mid();
    int d0, e0;
    bit ok;
    d0 = done_cnt;
    e0 = err_cnt;
    do_send(8'hED);
    wait_rts(ok);
    dev_smp = '0;
    run_device(1'b1, 0, 5);
    total++; if (dev_smp[4:0] !== 5'b11010) begin bad++; $display("[TB] FAIL rstmid_bits: got %b expected %b", dev_smp[4:0], 5'b11010); end
    total++; if (busy !== 1'b1 || ps2_dat_oe !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_bit4: got busy=%b dat_oe=%b expected 1 1", busy, ps2_dat_oe); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_async: got clk_oe=%b dat_oe=%b busy=%b expected 0 0 0", ps2_clk_oe, ps2_dat_oe, busy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (done_cnt - d0 != 0 || err_cnt - e0 != 0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_quiet: got done=%0d err=%0d busy=%b expected 0 0 0", done_cnt - d0, err_cnt - e0, busy); end
  endtask

  initial begin
    test_reset();
    test_tx("ed", 8'hED, 11'b11111011010);
    test_tx("x01", 8'h01, 11'b10000000010);
    test_tx("x00", 8'h00, 11'b11000000000);
    test_no_ack();
    test_timeout();
    test_busy_ignore();
    test_reset_mid();
    test_tx("fresh", 8'h01, 11'b10000000010);
    total++; if (both_cnt != 0) begin bad++; $display("[TB] FAIL done_err_overlap: got %0d expected 0", both_cnt); end
    total++; if (long_cnt != 0) begin bad++; $display("[TB] FAIL pulse_width: got %0d long pulses expected 0", long_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
